// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared glyph table, sampler states and counter width
package segment_pkg;

  localparam int CNT_W = 4;

  // Active-low glyphs, bit0=a .. bit6=g
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h18;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } sampler_state_t;

endpackage

// File: rtl/segment_pattern_decoder.sv
// rtl/segment_pattern_decoder.sv - inverse hex-to-segment table, flags non-glyph patterns
module segment_pattern_decoder
  import segment_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       err
);

  // Map each legal glyph back to its nibble; anything else is nibble 0 with err
  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (seg_n)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/segment_scan_receiver.sv
// rtl/segment_scan_receiver.sv - debounces a scanned 7-segment bus and assembles nibble frames
module segment_scan_receiver
  import segment_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Registered sample and the one before it (for the "unchanged" test)
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;
  logic [6:0]          prev_seg;
  logic [DIGITS-1:0]   prev_sel;

  sampler_state_t      state;
  sampler_state_t      state_n;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_n;
  logic                accept;

  logic                one_hot;
  logic                changed;

  logic [3:0]          nib;
  logic                dec_err;

  logic [DIGITS-1:0]   seen;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_err;
  logic                frame_done;

  assign one_hot    = $onehot(sel_q);
  assign changed    = ({seg_q, sel_q} != {prev_seg, prev_sel});
  assign frame_done = &seen;

  segment_pattern_decoder u_decoder (
    .seg_n  (seg_q),
    .nibble (nib),
    .err    (dec_err)
  );

  // Input stage: one register on the raw bus, plus a delayed copy for comparison
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_q    <= '0;
      sel_q    <= '0;
      prev_seg <= '0;
      prev_sel <= '0;
    end else begin
      seg_q    <= seg_n;
      sel_q    <= dig_sel;
      prev_seg <= seg_q;
      prev_sel <= sel_q;
    end
  end

  // Sampler state and stability counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next sampler state; an accept always lands in HOLD so a dwell is taken once
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (one_hot) state_n = accept ? HOLD : SETTLE;
        else         state_n = IDLE;
      end
      SETTLE: begin
        if (!one_hot)    state_n = IDLE;
        else if (accept) state_n = HOLD;
        else             state_n = SETTLE;
      end
      HOLD: begin
        if (!changed)      state_n = HOLD;
        else if (!one_hot) state_n = IDLE;
        else if (accept)   state_n = HOLD;
        else               state_n = SETTLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counter update and accept strobe; accept fires the cycle the count hits the threshold
  always_comb begin
    cnt_n  = cnt;
    accept = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = one_hot ? CNT_ONE : '0;
        accept = one_hot && (cnt_n == STABLE_CNT);
      end
      SETTLE: begin
        if (!one_hot)     cnt_n = '0;
        else if (changed) cnt_n = CNT_ONE;
        else              cnt_n = cnt + CNT_ONE;
        accept = one_hot && (cnt_n == STABLE_CNT);
      end
      HOLD: begin
        if (changed) begin
          cnt_n  = one_hot ? CNT_ONE : '0;
          accept = one_hot && (cnt_n == STABLE_CNT);
        end
      end
      default: cnt_n = '0;
    endcase
  end

  // Shadow slots: the accepted digit overwrites its slot (last write wins)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_val <= '0;
      shadow_err <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (accept && sel_q[i]) begin
          shadow_val[4*i +: 4] <= nib;
          shadow_err[i]        <= dec_err;
        end
      end
    end
  end

  // Seen mask: cleared on frame completion, an accept in that same cycle starts the next frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen <= '0;
    end else begin
      seen <= (frame_done ? '0 : seen) | (accept ? sel_q : '0);
    end
  end

  // Publish a complete frame one cycle after its last accept; outputs hold otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value       <= '0;
      digit_err   <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        value     <= shadow_val;
        digit_err <= shadow_err;
        frame_err <= |shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_segment_scan_receiver.sv
// tb/tb_segment_scan_receiver.sv - directed self-checking bench for segment_scan_receiver
module tb_segment_scan_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  dig_sel;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_count = 0;

  segment_scan_receiver #(
    .DIGITS        (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .value       (value),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clock = ~clock;

  // Count frame_valid pulses
  always @(negedge clock) begin
    if (frame_valid === 1'b1) fv_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] g, input int n);
    dig_sel = 4'(1 << d);
    seg_n   = g;
    repeat (n) @(negedge clock);
  endtask

  task automatic idle(input int n);
    dig_sel = 4'b0000;
    seg_n   = 7'h7F;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset   = 1'b0;
    seg_n   = 7'h7F;
    dig_sel = 4'b0000;
    #2;
    reset = 1'b1;
    #2;
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_digit_err", 32'(digit_err), 32'h0);
    chk("reset_frame_valid", 32'(frame_valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle bus: nothing happens for 100 cycles
    idle(100);
    chk("idle_fv_count", 32'(fv_count), 32'd0);
    chk("idle_value", 32'(value), 32'h0);

    // Legal frame 1,2,3,4 with exact frame_valid timing on the last digit
    show(0, 7'h79, 5);
    show(1, 7'h24, 5);
    show(2, 7'h30, 5);
    dig_sel = 4'b1000;
    seg_n   = 7'h19;
    repeat (4) @(negedge clock);
    chk("f1_fv_early", 32'(frame_valid), 32'h0);
    @(negedge clock);
    chk("f1_fv_pulse", 32'(frame_valid), 32'h1);
    chk("f1_value_at_pulse", 32'(value), 32'h4321);
    @(negedge clock);
    chk("f1_fv_one_cycle", 32'(frame_valid), 32'h0);
    idle(6);
    chk("f1_fv_count", 32'(fv_count), 32'd1);
    chk("f1_value", 32'(value), 32'h4321);
    chk("f1_digit_err", 32'(digit_err), 32'h0);
    chk("f1_frame_err", 32'(frame_err), 32'h0);

    // Glitch on digit 2: short '2' dwell is ignored, '3' is taken
    show(0, 7'h40, 5);
    show(1, 7'h79, 5);
    show(2, 7'h24, 2);
    show(2, 7'h30, 4);
    show(3, 7'h12, 5);
    idle(6);
    chk("glitch_fv_count", 32'(fv_count), 32'd2);
    chk("glitch_value", 32'(value), 32'h5310);

    // Illegal glyph on digit 1
    show(0, 7'h08, 5);
    show(1, 7'h7F, 5);
    show(2, 7'h46, 5);
    show(3, 7'h21, 5);
    idle(6);
    chk("illegal_fv_count", 32'(fv_count), 32'd3);
    chk("illegal_value", 32'(value), 32'hDC0A);
    chk("illegal_digit_err", 32'(digit_err), 32'h2);
    chk("illegal_frame_err", 32'(frame_err), 32'h1);

    // Multi-hot select ignored, digit 0 rescanned before the frame ends
    show(0, 7'h06, 5);
    dig_sel = 4'b0110;
    seg_n   = 7'h24;
    repeat (10) @(negedge clock);
    chk("multihot_fv_count", 32'(fv_count), 32'd3);
    show(1, 7'h02, 5);
    show(2, 7'h78, 5);
    show(0, 7'h40, 5);
    chk("partial_hidden_value", 32'(value), 32'hDC0A);
    chk("partial_fv_count", 32'(fv_count), 32'd3);
    show(3, 7'h00, 5);
    idle(6);
    chk("rescan_fv_count", 32'(fv_count), 32'd4);
    chk("rescan_value", 32'(value), 32'h8760);
    chk("rescan_frame_err", 32'(frame_err), 32'h0);

    // Reset mid-frame, then a fresh frame starting with the digit not yet seen
    show(0, 7'h79, 5);
    show(1, 7'h24, 5);
    show(2, 7'h30, 5);
    reset = 1'b1;
    #1;
    chk("async_reset_value", 32'(value), 32'h0);
    chk("async_reset_digit_err", 32'(digit_err), 32'h0);
    dig_sel = 4'b0000;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    show(3, 7'h46, 5);
    idle(6);
    chk("post_reset_no_frame", 32'(fv_count), 32'd4);
    show(0, 7'h18, 5);
    show(1, 7'h08, 5);
    show(2, 7'h03, 5);
    idle(6);
    chk("post_reset_fv_count", 32'(fv_count), 32'd5);
    chk("post_reset_value", 32'(value), 32'hCBA9);
    chk("post_reset_digit_err", 32'(digit_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
